// File: rtl/execute_unit.sv
// execute_unit: EX stage of the 5-stage pipeline. Computes the ALU result, store
// data and branch/jump redirect, then registers them into the EX/ME register
// using valid/ready handshakes on both sides.
// Optional macro EXEC_MUL_EN: op 11 becomes an iterative shift-add multiply
// (one bit per cycle). Without it, op 11 is a single-cycle op that yields 0.
//
// state | meaning
// IDLE  | ready for a new instruction
// MUL   | shift-add multiply iterating (EXEC_MUL_EN only)
// DONE  | product ready, waiting for a free EX/ME slot (EXEC_MUL_EN only)
module execute_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ID_EX_valid,
  output logic            ID_EX_ready,
  input  logic [XLEN-1:0] ID_EX_pc,
  input  logic [XLEN-1:0] ID_EX_rs1_data,
  input  logic [XLEN-1:0] ID_EX_rs2_data,
  input  logic [XLEN-1:0] ID_EX_imm,
  input  logic [3:0]      ID_EX_alu_op,
  input  logic            ID_EX_alu_src,
  input  logic [2:0]      ID_EX_br_cond,
  input  logic            ID_EX_branch,
  input  logic            ID_EX_jal,
  input  logic            ID_EX_jalr,
  input  logic [4:0]      ID_EX_rd,
  input  logic            ID_EX_RegWrite,
  input  logic            ID_EX_MemRead,
  input  logic            ID_EX_MemWrite,
  input  logic            ID_EX_MemtoReg,
  input  logic            flush,
  output logic            EX_ME_valid,
  input  logic            ME_EX_ready,
  output logic [XLEN-1:0] EX_ME_ALU_result,
  output logic [XLEN-1:0] EX_ME_data,
  output logic [4:0]      EX_ME_rd,
  output logic            EX_ME_RegWrite,
  output logic            EX_ME_MemRead,
  output logic            EX_ME_MemWrite,
  output logic            EX_ME_MemtoReg,
  output logic            EX_branch_taken,
  output logic [XLEN-1:0] EX_branch_target
);

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] redirect_pc;
  logic [4:0]      shamt;
  logic            cond_met;
  logic            redirect;
  logic            ex_me_free;
  logic            accept;
  logic            accept_direct;
  logic            in_idle;

  assign op_b        = ID_EX_alu_src ? ID_EX_imm : ID_EX_rs2_data;
  assign shamt       = op_b[4:0];
  assign ex_result   = (ID_EX_jal || ID_EX_jalr) ? (ID_EX_pc + XLEN'(4)) : alu_res;
  assign redirect    = ID_EX_jal || ID_EX_jalr || (ID_EX_branch && cond_met);
  assign redirect_pc = ID_EX_jalr ? ((ID_EX_rs1_data + ID_EX_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                                  : (ID_EX_pc + ID_EX_imm);
  assign ex_me_free  = !EX_ME_valid || ME_EX_ready;
  assign ID_EX_ready = in_idle && ex_me_free;
  assign accept      = ID_EX_valid && ID_EX_ready && !flush;

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int CW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mul_mcand;
  logic [XLEN-1:0] mul_mplr;
  logic [CW-1:0]   mul_cnt;
  logic [XLEN-1:0] mul_data;
  logic [4:0]      mul_rd;
  logic            mul_regwrite;
  logic            mul_memread;
  logic            mul_memwrite;
  logic            mul_memtoreg;
  logic            mul_op;

  assign in_idle       = (state == IDLE);
  assign mul_op        = (ID_EX_alu_op == 4'd11);
  assign accept_direct = accept && !mul_op;
`else
  assign in_idle       = 1'b1;
  assign accept_direct = accept;
`endif

  // ALU: operation select on operand A and the muxed operand B
  always_comb begin
    alu_res = '0;
    case (ID_EX_alu_op)
      4'd0:    alu_res = ID_EX_rs1_data + op_b;
      4'd1:    alu_res = ID_EX_rs1_data - op_b;
      4'd2:    alu_res = ID_EX_rs1_data << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(ID_EX_rs1_data) < $signed(op_b))};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, (ID_EX_rs1_data < op_b)};
      4'd5:    alu_res = ID_EX_rs1_data ^ op_b;
      4'd6:    alu_res = ID_EX_rs1_data >> shamt;
      4'd7:    alu_res = $unsigned($signed(ID_EX_rs1_data) >>> shamt);
      4'd8:    alu_res = ID_EX_rs1_data | op_b;
      4'd9:    alu_res = ID_EX_rs1_data & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Branch condition compare on rs1 vs rs2
  always_comb begin
    cond_met = 1'b0;
    case (ID_EX_br_cond)
      3'd0:    cond_met = (ID_EX_rs1_data == ID_EX_rs2_data);
      3'd1:    cond_met = (ID_EX_rs1_data != ID_EX_rs2_data);
      3'd4:    cond_met = ($signed(ID_EX_rs1_data) <  $signed(ID_EX_rs2_data));
      3'd5:    cond_met = ($signed(ID_EX_rs1_data) >= $signed(ID_EX_rs2_data));
      3'd6:    cond_met = (ID_EX_rs1_data <  ID_EX_rs2_data);
      3'd7:    cond_met = (ID_EX_rs1_data >= ID_EX_rs2_data);
      default: cond_met = 1'b0;
    endcase
  end

  // EX/ME pipeline register, redirect pulse and multiply state machine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EX_ME_valid      <= 1'b0;
      EX_ME_ALU_result <= '0;
      EX_ME_data       <= '0;
      EX_ME_rd         <= '0;
      EX_ME_RegWrite   <= 1'b0;
      EX_ME_MemRead    <= 1'b0;
      EX_ME_MemWrite   <= 1'b0;
      EX_ME_MemtoReg   <= 1'b0;
      EX_branch_taken  <= 1'b0;
      EX_branch_target <= '0;
`ifdef EXEC_MUL_EN
      state        <= IDLE;
      mul_acc      <= '0;
      mul_mcand    <= '0;
      mul_mplr     <= '0;
      mul_cnt      <= '0;
      mul_data     <= '0;
      mul_rd       <= '0;
      mul_regwrite <= 1'b0;
      mul_memread  <= 1'b0;
      mul_memwrite <= 1'b0;
      mul_memtoreg <= 1'b0;
`endif
    end else begin
      EX_branch_taken <= 1'b0;
      // Drain: side-effecting controls are cleared so a stale entry can do no harm
      if (ex_me_free) begin
        EX_ME_valid    <= 1'b0;
        EX_ME_RegWrite <= 1'b0;
        EX_ME_MemRead  <= 1'b0;
        EX_ME_MemWrite <= 1'b0;
      end
      if (accept_direct) begin
        EX_ME_valid      <= 1'b1;
        EX_ME_ALU_result <= ex_result;
        EX_ME_data       <= ID_EX_rs2_data;
        EX_ME_rd         <= ID_EX_rd;
        EX_ME_RegWrite   <= ID_EX_RegWrite;
        EX_ME_MemRead    <= ID_EX_MemRead;
        EX_ME_MemWrite   <= ID_EX_MemWrite;
        EX_ME_MemtoReg   <= ID_EX_MemtoReg;
        EX_branch_taken  <= redirect;
        EX_branch_target <= redirect_pc;
      end
`ifdef EXEC_MUL_EN
      case (state)
        IDLE: begin
          if (accept && mul_op) begin
            state        <= MUL;
            mul_acc      <= '0;
            mul_mcand    <= ID_EX_rs1_data;
            mul_mplr     <= op_b;
            mul_cnt      <= CW'(XLEN - 1);
            mul_data     <= ID_EX_rs2_data;
            mul_rd       <= ID_EX_rd;
            mul_regwrite <= ID_EX_RegWrite;
            mul_memread  <= ID_EX_MemRead;
            mul_memwrite <= ID_EX_MemWrite;
            mul_memtoreg <= ID_EX_MemtoReg;
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (mul_mplr[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand <= mul_mcand << 1;
            mul_mplr  <= mul_mplr >> 1;
            if (mul_cnt == '0) state <= DONE;
            else mul_cnt <= mul_cnt - 1'b1;
          end
        end
        DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (ex_me_free) begin
            state            <= IDLE;
            EX_ME_valid      <= 1'b1;
            EX_ME_ALU_result <= mul_acc;
            EX_ME_data       <= mul_data;
            EX_ME_rd         <= mul_rd;
            EX_ME_RegWrite   <= mul_regwrite;
            EX_ME_MemRead    <= mul_memread;
            EX_ME_MemWrite   <= mul_memwrite;
            EX_ME_MemtoReg   <= mul_memtoreg;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vectors with hand-computed expectations for
// execute_unit (both default build and EXEC_MUL_EN build).
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_EX_valid;
  logic        ID_EX_ready;
  logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [3:0]  ID_EX_alu_op;
  logic        ID_EX_alu_src;
  logic [2:0]  ID_EX_br_cond;
  logic        ID_EX_branch, ID_EX_jal, ID_EX_jalr;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic        flush;
  logic        EX_ME_valid;
  logic        ME_EX_ready;
  logic [31:0] EX_ME_ALU_result, EX_ME_data;
  logic [4:0]  EX_ME_rd;
  logic        EX_ME_RegWrite, EX_ME_MemRead, EX_ME_MemWrite, EX_ME_MemtoReg;
  logic        EX_branch_taken;
  logic [31:0] EX_branch_target;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  execute_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ID_EX_valid(ID_EX_valid), .ID_EX_ready(ID_EX_ready),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_alu_src(ID_EX_alu_src),
    .ID_EX_br_cond(ID_EX_br_cond), .ID_EX_branch(ID_EX_branch), .ID_EX_jal(ID_EX_jal),
    .ID_EX_jalr(ID_EX_jalr), .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .flush(flush),
    .EX_ME_valid(EX_ME_valid), .ME_EX_ready(ME_EX_ready),
    .EX_ME_ALU_result(EX_ME_ALU_result), .EX_ME_data(EX_ME_data), .EX_ME_rd(EX_ME_rd),
    .EX_ME_RegWrite(EX_ME_RegWrite), .EX_ME_MemRead(EX_ME_MemRead),
    .EX_ME_MemWrite(EX_ME_MemWrite), .EX_ME_MemtoReg(EX_ME_MemtoReg),
    .EX_branch_taken(EX_branch_taken), .EX_branch_target(EX_branch_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    ID_EX_valid = 0; ID_EX_pc = 0; ID_EX_rs1_data = 0; ID_EX_rs2_data = 0; ID_EX_imm = 0;
    ID_EX_alu_op = 0; ID_EX_alu_src = 0; ID_EX_br_cond = 0; ID_EX_branch = 0;
    ID_EX_jal = 0; ID_EX_jalr = 0; ID_EX_rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
    ID_EX_MemWrite = 0; ID_EX_MemtoReg = 0; flush = 0;
  endtask

  initial begin
    reset = 0; ME_EX_ready = 1; nop();
    tick(); tick();
    chk("rst_valid", EX_ME_valid, 0);
    chk("rst_result", EX_ME_ALU_result, 0);
    chk("rst_taken", EX_branch_taken, 0);
    chk("rst_ready", ID_EX_ready, 1);
    reset = 1;
    tick();

    // ADD rs1=5 + imm=-3
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 0; ID_EX_rs1_data = 5; ID_EX_imm = 32'hFFFFFFFD;
    ID_EX_alu_src = 1; ID_EX_rd = 7; ID_EX_RegWrite = 1; ID_EX_MemtoReg = 1;
    tick();
    chk("add_valid", EX_ME_valid, 1);
    chk("add_result", EX_ME_ALU_result, 2);
    chk("add_rd", EX_ME_rd, 7);
    chk("add_regwrite", EX_ME_RegWrite, 1);
    chk("add_memtoreg", EX_ME_MemtoReg, 1);
    chk("add_taken", EX_branch_taken, 0);

    nop();
    tick();
    chk("drain_valid", EX_ME_valid, 0);
    chk("drain_regwrite", EX_ME_RegWrite, 0);

    // SRA then SRL, back to back
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 7; ID_EX_rs1_data = 32'h80000000; ID_EX_rs2_data = 4;
    tick();
    chk("sra_result", EX_ME_ALU_result, 32'hF8000000);
    ID_EX_alu_op = 6;
    tick();
    chk("srl_result", EX_ME_ALU_result, 32'h08000000);
    chk("srl_valid", EX_ME_valid, 1);

    // BLTU taken, BLT not taken
    nop(); ID_EX_valid = 1; ID_EX_branch = 1; ID_EX_br_cond = 6; ID_EX_rs1_data = 1;
    ID_EX_rs2_data = 32'hFFFFFFFF; ID_EX_pc = 32'h100; ID_EX_imm = 32'h20;
    tick();
    chk("bltu_taken", EX_branch_taken, 1);
    chk("bltu_target", EX_branch_target, 32'h120);
    ID_EX_br_cond = 4;
    tick();
    chk("blt_taken", EX_branch_taken, 0);
    ID_EX_br_cond = 2; ID_EX_rs1_data = 3; ID_EX_rs2_data = 3;
    tick();
    chk("cond2_taken", EX_branch_taken, 0);

    // JALR and JAL
    nop(); ID_EX_valid = 1; ID_EX_jalr = 1; ID_EX_pc = 32'h40; ID_EX_rs1_data = 32'h1003;
    ID_EX_imm = 4; ID_EX_alu_src = 1; ID_EX_rd = 1; ID_EX_RegWrite = 1;
    tick();
    chk("jalr_taken", EX_branch_taken, 1);
    chk("jalr_target", EX_branch_target, 32'h1006);
    chk("jalr_link", EX_ME_ALU_result, 32'h44);
    chk("jalr_regwrite", EX_ME_RegWrite, 1);
    nop(); ID_EX_valid = 1; ID_EX_jal = 1; ID_EX_pc = 32'h200; ID_EX_imm = 32'hFFFFFFF8;
    ID_EX_rd = 1; ID_EX_RegWrite = 1;
    tick();
    chk("jal_taken", EX_branch_taken, 1);
    chk("jal_target", EX_branch_target, 32'h1F8);
    chk("jal_link", EX_ME_ALU_result, 32'h204);
    nop();
    tick();

    // Store accepted, then held for 3 cycles by back-pressure
    nop(); ID_EX_valid = 1; ID_EX_rs1_data = 32'h1000; ID_EX_imm = 8; ID_EX_alu_src = 1;
    ID_EX_rs2_data = 32'hDEADBEEF; ID_EX_MemWrite = 1; ME_EX_ready = 0;
    tick();
    chk("st_valid", EX_ME_valid, 1);
    chk("st_addr", EX_ME_ALU_result, 32'h1008);
    nop(); ID_EX_valid = 1; ID_EX_rs1_data = 32'h10; ID_EX_imm = 32'h20; ID_EX_alu_src = 1;
    ID_EX_rs2_data = 32'h55; ID_EX_rd = 3; ID_EX_RegWrite = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ready", ID_EX_ready, 0);
      chk("hold_addr", EX_ME_ALU_result, 32'h1008);
      chk("hold_data", EX_ME_data, 32'hDEADBEEF);
      chk("hold_memwrite", EX_ME_MemWrite, 1);
      chk("hold_valid", EX_ME_valid, 1);
    end
    ME_EX_ready = 1;
    #1;
    chk("release_ready", ID_EX_ready, 1);
    tick();
    chk("b2b_valid", EX_ME_valid, 1);
    chk("b2b_result", EX_ME_ALU_result, 32'h30);
    chk("b2b_data", EX_ME_data, 32'h55);
    chk("b2b_memwrite", EX_ME_MemWrite, 0);
    chk("b2b_rd", EX_ME_rd, 3);

    // Flush keeps older EX/ME content and drops the incoming instruction
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 5; ID_EX_rs1_data = 32'hF0; ID_EX_rs2_data = 32'h0F;
    flush = 1; ME_EX_ready = 0;
    tick();
    chk("flush_keep_valid", EX_ME_valid, 1);
    chk("flush_keep_result", EX_ME_ALU_result, 32'h30);
    ME_EX_ready = 1;
    tick();
    chk("flush_drop_valid", EX_ME_valid, 0);

    // Undefined op and PASSB
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 12; ID_EX_rs1_data = 5; ID_EX_rs2_data = 3;
    tick();
    chk("op12_result", EX_ME_ALU_result, 0);
    ID_EX_alu_op = 10; ID_EX_imm = 32'h12345000; ID_EX_alu_src = 1;
    tick();
    chk("passb_result", EX_ME_ALU_result, 32'h12345000);
    nop();
    tick();

`ifdef EXEC_MUL_EN
    // Iterative multiply: result visible 33 cycles after acceptance
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 11; ID_EX_rs1_data = 7; ID_EX_rs2_data = 32'hFFFFFFFF;
    ID_EX_rd = 9; ID_EX_RegWrite = 1;
    tick();
    nop();
    chk("mul_busy_ready", ID_EX_ready, 0);
    repeat (32) tick();
    chk("mul_early_valid", EX_ME_valid, 0);
    chk("mul_late_ready", ID_EX_ready, 0);
    tick();
    chk("mul_valid", EX_ME_valid, 1);
    chk("mul_result", EX_ME_ALU_result, 32'hFFFFFFF9);
    chk("mul_rd", EX_ME_rd, 9);
    chk("mul_ready_after", ID_EX_ready, 1);

    // Flush at cycle 10 aborts the multiply
    ID_EX_valid = 1; ID_EX_alu_op = 11; ID_EX_rs1_data = 3; ID_EX_rs2_data = 5; ID_EX_rd = 4;
    ID_EX_RegWrite = 1;
    tick();
    nop();
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("mulflush_ready", ID_EX_ready, 1);
    chk("mulflush_valid", EX_ME_valid, 0);
    repeat (30) tick();
    chk("mulflush_no_output", EX_ME_valid, 0);
    chk("mulflush_stale", EX_ME_ALU_result, 32'hFFFFFFF9);

    // Reset pulse mid-multiply
    ID_EX_valid = 1; ID_EX_alu_op = 11; ID_EX_rs1_data = 3; ID_EX_rs2_data = 5;
    tick();
    nop();
    repeat (5) tick();
`else
    // Without the multiplier op 11 is a single-cycle op yielding 0
    nop(); ID_EX_valid = 1; ID_EX_alu_op = 11; ID_EX_rs1_data = 7; ID_EX_rs2_data = 32'hFFFFFFFF;
    ID_EX_rd = 9; ID_EX_RegWrite = 1;
    tick();
    chk("mul_off_valid", EX_ME_valid, 1);
    chk("mul_off_result", EX_ME_ALU_result, 0);
    chk("mul_off_ready", ID_EX_ready, 1);
    ME_EX_ready = 0;
    nop();
    tick();
`endif

    // Asynchronous reset clears every output register without a clock edge
    reset = 0;
    #2;
    chk("arst_valid", EX_ME_valid, 0);
    chk("arst_result", EX_ME_ALU_result, 0);
    chk("arst_data", EX_ME_data, 0);
    chk("arst_rd", EX_ME_rd, 0);
    chk("arst_regwrite", EX_ME_RegWrite, 0);
    chk("arst_target", EX_branch_target, 0);
    tick();
    reset = 1; ME_EX_ready = 1;
    repeat (40) tick();
    chk("arst_no_output", EX_ME_valid, 0);
    chk("arst_ready", ID_EX_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- EX stage of the 5-stage RISC pipeline.
- Takes decoded operands from ID and computes the ALU result, store data and branch/jump resolution.
- Registers the result into the EX/ME pipeline register that drives memory_unit.
- Uses a valid/ready handshake on both sides, so a stalled memory stage back-pressures decode without losing instructions.

Parameters:
XLEN, 32, datapath width of operands, results and PC; all XLEN-wide ports scale with it.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
ID_EX_valid  input  1  decode presents an instruction
ID_EX_ready  output  1  EX accepts the instruction this cycle
ID_EX_pc  input  XLEN  instruction PC
ID_EX_rs1_data  input  XLEN  operand A
ID_EX_rs2_data  input  XLEN  operand B / store data
ID_EX_imm  input  XLEN  sign-extended immediate
ID_EX_alu_op  input  4  ALU operation code
ID_EX_alu_src  input  1  1 = operand B is imm
ID_EX_br_cond  input  3  branch funct3
ID_EX_branch  input  1  conditional branch
ID_EX_jal  input  1  JAL
ID_EX_jalr  input  1  JALR
ID_EX_rd  input  5  destination register
ID_EX_RegWrite  input  1  writeback enable
ID_EX_MemRead  input  1  load
ID_EX_MemWrite  input  1  store
ID_EX_MemtoReg  input  1  WB source select
flush  input  1  drop incoming/in-progress instruction
EX_ME_valid  output  1  EX/ME register holds an instruction
ME_EX_ready  input  1  memory stage accepts EX/ME contents
EX_ME_ALU_result  output  XLEN  ALU result / address / link value
EX_ME_data  output  XLEN  store data (rs2)
EX_ME_rd  output  5  destination register
EX_ME_RegWrite  output  1  forwarded control
EX_ME_MemRead  output  1  forwarded control
EX_ME_MemWrite  output  1  forwarded control
EX_ME_MemtoReg  output  1  forwarded control
EX_branch_taken  output  1  one-cycle redirect pulse
EX_branch_target  output  XLEN  redirect PC, valid with pulse

Behaviour:
- Reset (reset=0, async): every output register is 0, EX_ME_valid=0, EX_branch_taken=0, state=IDLE. Reset mid-multiply aborts the operation with no output.
- ALU operand B is imm if alu_src=1, else rs2.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI), 11 MUL.
  - Shift amount is B[4:0].
  - All arithmetic wraps modulo 2^XLEN.
  - Codes 12-15 yield 0.
- Handshake:
  - ID_EX_ready = (state==IDLE) && (!EX_ME_valid || ME_EX_ready).
  - An instruction is accepted when ID_EX_valid && ID_EX_ready && !flush.
- Latency: a non-MUL instruction appears in EX_ME_* on the cycle after acceptance (1 cycle).
- Hold: when EX_ME_valid && !ME_EX_ready, all EX_ME_* outputs hold stable.
- Drain: if ME_EX_ready=1 and nothing is accepted, EX_ME_valid goes to 0. Data fields may hold stale values; RegWrite/MemRead/MemWrite are forced to 0.
- Branch conditions on rs1 vs rs2: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2 and 3 are never taken.
- Redirect targets:
  - Taken branch and JAL: target = pc+imm.
  - JALR: target = (rs1+imm) & ~1.
- Link value: for JAL/JALR, EX_ME_ALU_result = pc+4 and RegWrite is passed through.
- EX_branch_taken:
  - Registered, asserted for exactly one cycle, in the same cycle the instruction first appears in EX_ME.
  - Not re-asserted while the instruction is held by back-pressure.
- Flush: the incoming instruction is discarded and an in-progress MUL is aborted (state→IDLE). The existing EX_ME register content is older, so it is kept and not cleared.
- State machine: IDLE, MUL (only with the feature), DONE.
  - IDLE→MUL on accepting op 11.
  - MUL→DONE after 32 iterations.
  - DONE→IDLE when the result is written into EX_ME, i.e. when EX_ME is free (!EX_ME_valid || ME_EX_ready).
- Simultaneous ME_EX_ready and acceptance: the old contents leave and the new contents load in the same edge, with no bubble.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined:
  - Op 11 runs an iterative shift-add multiply giving the low XLEN bits of rs1*B, one bit per cycle.
  - ID_EX_ready=0 from the acceptance cycle until the result is loaded.
  - The result reaches EX_ME 33 cycles after acceptance when not back-pressured.
- Not defined: op 11 is a 1-cycle op with result 0; the MUL and DONE states do not exist.

Test Plan:
- ADD rs1=5, imm=-3, alu_src=1 -> next cycle EX_ME_valid=1, ALU_result=2, rd and controls passed through.
- SRA rs1=0x80000000, rs2=4 -> ALU_result=0xF8000000; SRL of the same operands -> 0x08000000.
- BLTU rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=0x20 -> EX_branch_taken pulses 1 cycle with target=0x120. BLT with the same operands -> no pulse.
- JALR pc=0x40, rs1=0x1003, imm=4 -> target=0x1006, ALU_result=0x44.
- Store with ME_EX_ready=0 for 3 cycles -> EX_ME_* stable and ID_EX_ready=0. ME_EX_ready=1 plus a new ADD -> back-to-back load with no bubble.
- EXEC_MUL_EN: rs1=7, rs2=0xFFFFFFFF -> ALU_result=0xFFFFFFF9 after 33 cycles. Flush at cycle 10 -> no output and ID_EX_ready=1 next cycle. Reset pulse mid-op -> all outputs 0.
